// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART state encodings, frame constants and baud divisor, shared by TX and RX
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_STRT = 3'd1,
        ST_BITS = 3'd2,
        ST_PAR  = 3'd3,
        ST_STP  = 3'd4,
        ST_ACK  = 3'd5
    } uart_state_e;

    localparam int unsigned DATA_BITS    = 8;
    localparam int unsigned FRAME_BITS   = 11;
    localparam int unsigned BAUD_TIMER_W = 32;

    function automatic int unsigned baud_timer_max(input int unsigned clk_hz,
                                                   input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// rtl/uart_baud_timer.sv - bit-period timer: counts 0..BAUD_TIMER_MAX-1, flags the last count
module uart_baud_timer
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_TIMER_MAX = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic expired
);

    logic [BAUD_TIMER_W-1:0] timer_q;
    logic [BAUD_TIMER_W-1:0] timer_d;

    assign expired = (timer_q == BAUD_TIMER_W'(BAUD_TIMER_MAX - 1));

    always_comb begin
        timer_d = timer_q + 1'b1;
        if (clr || expired) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, 8 data bits LSB first, parity, stop
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = 100000000,
    parameter int unsigned BAUD_RATE     = 19200,
    parameter int unsigned PARITY_MODE   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] din,
    output logic                 busy,
    output logic                 tx_out
);

    localparam int unsigned BAUD_TIMER_MAX = baud_timer_max(CLK_FREQUENCY, BAUD_RATE);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 parity_q, parity_d;
    logic [3:0]           bitcnt_q, bitcnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 tmr_clr;
    logic                 tmr_expired;

    uart_baud_timer #(
        .BAUD_TIMER_MAX(BAUD_TIMER_MAX)
    ) u_baud_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        parity_d = parity_q;
        bitcnt_d = bitcnt_q;
        tmr_clr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (send) begin
                    data_d   = din;
                    parity_d = (PARITY_MODE != 0) ? ~^din : ^din;
                    tmr_clr  = 1'b1;
                    state_d  = ST_STRT;
                end
            end
            ST_STRT: begin
                if (tmr_expired) begin
                    bitcnt_d = 4'd0;
                    state_d  = ST_BITS;
                end
            end
            ST_BITS: begin
                if (tmr_expired) begin
                    if (bitcnt_q == 4'd7) begin
                        state_d = ST_PAR;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
            end
            ST_PAR: begin
                if (tmr_expired) state_d = ST_STP;
            end
            ST_STP: begin
                if (tmr_expired) state_d = ST_ACK;
            end
            ST_ACK: begin
                if (!send) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs decode the next state so the line changes on the same edge as the state.
        tx_d   = 1'b1;
        busy_d = 1'b0;
        case (state_d)
            ST_STRT: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            ST_BITS: begin
                tx_d   = data_d[bitcnt_d[2:0]];
                busy_d = 1'b1;
            end
            ST_PAR: begin
                tx_d   = parity_d;
                busy_d = 1'b1;
            end
            ST_STP: begin
                busy_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            parity_q <= 1'b0;
            bitcnt_q <= 4'd0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            bitcnt_q <= bitcnt_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    assign tx_out = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx, odd- and even-parity instances side by side
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send = 1'b0;
    logic [7:0] din = 8'h00;
    logic       busy_odd, tx_odd;
    logic       busy_even, tx_even;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQUENCY(1000), .BAUD_RATE(100), .PARITY_MODE(1)) dut_odd (
        .clk(clk), .rst(rst), .send(send), .din(din), .busy(busy_odd), .tx_out(tx_odd)
    );

    uart_tx #(.CLK_FREQUENCY(1000), .BAUD_RATE(100), .PARITY_MODE(0)) dut_even (
        .clk(clk), .rst(rst), .send(send), .din(din), .busy(busy_even), .tx_out(tx_even)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Entered at the negedge where the frame starts (started=1) or one negedge before
    // the send pulse (started=0). With chain=1 the next send is issued at the earliest
    // legal cycle and the task returns at the negedge of the next frame's first cycle.
    task automatic run_frame(input logic [7:0] d, input logic p_odd, input logic p_even,
                             input bit started, input bit chain, input logic [7:0] next_d);
        int   busy_cnt;
        int   b;
        logic e_odd, e_even;
        if (!started) begin
            din  = d;
            send = 1'b1;
            @(negedge clk);
            send = 1'b0;
        end
        busy_cnt = 0;
        for (int c = 0; c < 125; c++) begin
            if (c < 110 && (c % 10) == 5) begin
                b = c / 10;
                if (b == 0) begin
                    e_odd = 1'b0; e_even = 1'b0;
                end else if (b <= 8) begin
                    e_odd = d[b-1]; e_even = d[b-1];
                end else if (b == 9) begin
                    e_odd = p_odd; e_even = p_even;
                end else begin
                    e_odd = 1'b1; e_even = 1'b1;
                end
                check($sformatf("tx_odd_%02h_bit%0d", d, b), tx_odd, e_odd);
                check($sformatf("tx_even_%02h_bit%0d", d, b), tx_even, e_even);
            end
            if (busy_odd) busy_cnt++;
            if (chain && c == 111) begin
                din  = next_d;
                send = 1'b1;
            end
            @(negedge clk);
            if (chain && c == 111) begin
                send = 1'b0;
                check("b2b_start_tx", tx_odd, 1'b0);
                check("b2b_start_busy", busy_odd, 1'b1);
                break;
            end
        end
        check($sformatf("busy_len_%02h", d), busy_cnt, 110);
        if (!chain) check($sformatf("idle_after_%02h", d), tx_odd, 1'b1);
    endtask

    initial begin
        int rises;
        int busy_cnt;
        logic busy_prev;

        // Reset idle
        #12 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            check("reset_tx", {tx_odd, tx_even}, 2'b11);
            check("reset_busy", {busy_odd, busy_even}, 2'b00);
            @(negedge clk);
        end

        // 0x41: two ones -> odd parity 1, even 0; chained into 0x00 at minimum spacing
        run_frame(8'h41, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        run_frame(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        run_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        // 0x07: three ones -> odd parity 0, even 1
        run_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        // send held high: exactly one frame
        din = 8'hA5;
        send = 1'b1;
        rises = 0;
        busy_cnt = 0;
        busy_prev = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy_odd && !busy_prev) rises++;
            if (busy_odd) busy_cnt++;
            busy_prev = busy_odd;
        end
        check("held_frames", rises, 1);
        check("held_busy_len", busy_cnt, 110);
        check("held_tx_idle", tx_odd, 1'b1);
        send = 1'b0;
        repeat (3) @(negedge clk);
        check("held_no_retrigger", busy_odd, 1'b0);
        run_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // async reset mid-frame
        din = 8'h41;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (45) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx", {tx_odd, tx_even}, 2'b11);
        check("midrst_busy", {busy_odd, busy_even}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("postrst_idle", busy_odd, 1'b0);
        // 0x3C: four ones -> odd parity 1, even 0
        run_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
